framebuffer_rect_writer: RTL and testbench



---
 rtl/framebuffer_rect_writer_if.sv | 27 ++
 rtl/framebuffer_rect_writer.sv | 102 ++++++++++
 tb/tb_framebuffer_rect_writer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_rect_writer_if.sv
// Command and RAM-write bundle for framebuffer_rect_writer. The controller holds the
// master side and the writer the slave side. ADDR_W must match the writer's ADDR_W.
interface framebuffer_rect_writer_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic [8:0]        x0;
  logic [7:0]        y0;
  logic [8:0]        width;
  logic [7:0]        height;
  logic [2:0]        color;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] address;
  logic [2:0]        data;
  logic              wren;

  modport master (
    output start, x0, y0, width, height, color,
    input  busy, done, address, data, wren
  );

  modport slave (
    input  start, x0, y0, width, height, color,
    output busy, done, address, data, wren
  );
endinterface

// File: rtl/framebuffer_rect_writer.sv
// Fills an axis-aligned rectangle of one colour into the frame-buffer RAM, one pixel per clock.
// Define FB_RECT_CLIP_EN to suppress writes to pixels that fall off the visible screen.
module framebuffer_rect_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17
) (
  input logic clock,
  input logic reset,
  framebuffer_rect_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] width;
    logic [7:0] height;
    logic [2:0] color;
  } cmd_t;

  if (SCREEN_W * SCREEN_H > (1 << ADDR_W)) begin : g_bad_cfg
    $error("screen does not fit the address bus");
  end

  state_t            state, state_nxt;
  cmd_t              cmd;
  logic [ADDR_W-1:0] row_base;
  logic [8:0]        cx;
  logic [7:0]        ry;
  logic              row_end, last, pix_en;

  assign row_end = (cx == cmd.width - 9'd1);
  assign last    = row_end && (ry == cmd.height - 8'd1);

`ifdef FB_RECT_CLIP_EN
  logic [9:0] col;
  logic [8:0] row;
  assign col    = {1'b0, cmd.x0} + {1'b0, cx};
  assign row    = {1'b0, cmd.y0} + {1'b0, ry};
  // Off-screen pixels still take their cycle so command duration never depends on position.
  assign pix_en = (col < 10'(SCREEN_W)) && (row < 9'(SCREEN_H));
`else
  assign pix_en = 1'b1;
`endif

  // The done cycle reads as IDLE internally, so start is held off until done has dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.done) state_nxt = SETUP;
      SETUP:   state_nxt = (cmd.width == '0 || cmd.height == '0) ? DONE : WRITE;
      WRITE:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cmd         <= '0;
      row_base    <= '0;
      cx          <= '0;
      ry          <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wren    <= 1'b0;
      bus.address <= '0;
      bus.data    <= '0;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt != IDLE) || (state == DONE);
      bus.done <= (state == DONE);
      bus.wren <= (state == WRITE) && pix_en;
      case (state)
        IDLE: if (state_nxt == SETUP)
          cmd <= '{x0: bus.x0, y0: bus.y0, width: bus.width, height: bus.height, color: bus.color};
        SETUP: begin
          row_base <= ADDR_W'(cmd.y0) * ADDR_W'(SCREEN_W) + ADDR_W'(cmd.x0);
          cx       <= '0;
          ry       <= '0;
        end
        WRITE: begin
          bus.address <= row_base + ADDR_W'(cx);
          bus.data    <= cmd.color;
          // Row stride is added rather than multiplied so the pixel loop stays adder-only.
          if (row_end) begin
            cx       <= '0;
            ry       <= ry + 8'd1;
            row_base <= row_base + ADDR_W'(SCREEN_W);
          end else begin
            cx <= cx + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_rect_writer.sv
// Self-checking bench for framebuffer_rect_writer: directed table, hand sequences and
// random rectangles checked against a pixel-list reference model.
module tb_framebuffer_rect_writer;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int AW = 17;

  logic clock = 1'b0;
  logic reset;

  framebuffer_rect_writer_if #(.ADDR_W(AW)) bus ();

  framebuffer_rect_writer #(.SCREEN_W(SW), .SCREEN_H(SH), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct { int idx; int addr; int data; } wr_t;
  typedef struct { int x; int y; int w; int h; int c; int n; int first; int last; int done_idx; } vec_t;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  done_q[$];
  int  idle_seen, abort_idx, timed_out;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: pixel i in row-major order appears in the cycle after edge k+2+i.
  function automatic int exp_done_idx(input int w, input int h);
    return (w == 0 || h == 0) ? 2 : 2 + w * h;
  endfunction

  task automatic build_model(input int x, input int y, input int w, input int h, input int c);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        int ax, ay;
        bit keep;
        ax = x + k;
        ay = y + r;
        keep = 1'b1;
`ifdef FB_RECT_CLIP_EN
        keep = (ax < SW) && (ay < SH);
`endif
        if (keep) exp_q.push_back('{2 + r * w + k, (ay * SW + ax) % (1 << AW), c});
      end
    end
  endtask

  // Issues one command, then samples every cycle at the falling edge until busy has been
  // low for 'tail' cycles. Optional second start pulse and mid-command reset.
  task automatic run(input int x, input int y, input int w, input int h, input int c,
                     input int inject_at, input int abort_after, input int tail);
    int idx, budget;
    bit aborted;
    idx = 0;
    budget = w * h + 40;
    aborted = 1'b0;
    wr_q.delete();
    done_q.delete();
    idle_seen = -1;
    abort_idx = -1;
    timed_out = 0;
    @(negedge clock);
    bus.start  = 1'b1;
    bus.x0     = 9'(x);
    bus.y0     = 8'(y);
    bus.width  = 9'(w);
    bus.height = 8'(h);
    bus.color  = 3'(c);
    @(negedge clock);
    forever begin
      if (bus.wren) wr_q.push_back('{idx, int'(bus.address), int'(bus.data)});
      if (bus.done) done_q.push_back(idx);
      if (!bus.busy && idle_seen < 0) idle_seen = idx;
      if (idle_seen >= 0 && idx >= idle_seen + tail) break;
      if (idx >= budget) begin
        timed_out = 1;
        break;
      end
      bus.start = (idx == inject_at);
      if (bus.start) bus.x0 = 9'd100;
      reset = 1'b0;
      if (abort_after > 0 && !aborted && wr_q.size() == abort_after) begin
        reset = 1'b1;
        aborted = 1'b1;
        abort_idx = idx;
      end
      @(negedge clock);
      idx++;
    end
    bus.start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int first_bad(input int limit);
    for (int i = 0; i < limit && i < exp_q.size() && i < wr_q.size(); i++)
      if (wr_q[i].idx != exp_q[i].idx || wr_q[i].addr != exp_q[i].addr ||
          wr_q[i].data != exp_q[i].data) return i;
    return -1;
  endfunction

  task automatic check_cmd(input string tag, input int x, input int y, input int w,
                           input int h, input int c);
    build_model(x, y, w, h, c);
    chk({tag, ".timeout"}, timed_out, 0);
    chk({tag, ".wr_count"}, wr_q.size(), exp_q.size());
    chk({tag, ".wr_seq_first_bad"}, first_bad(exp_q.size()), -1);
    chk({tag, ".done_count"}, done_q.size(), 1);
    chk({tag, ".done_idx"}, done_q.size() > 0 ? done_q[0] : -1, exp_done_idx(w, h));
    chk({tag, ".busy_fall"}, idle_seen, exp_done_idx(w, h) + 1);
  endtask

  initial begin
    vec_t tbl[4];
    reset = 1'b1;
    bus.start = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.width = '0;
    bus.height = '0;
    bus.color = '0;
    repeat (3) @(negedge clock);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk("rst.wren", int'(bus.wren), 0);
    chk("rst.address", int'(bus.address), 0);
    chk("rst.data", int'(bus.data), 0);
    reset = 1'b0;

    // Second start during WRITE must be dropped.
    run(0, 0, 4, 1, 6, 3, 0, 8);
    check_cmd("busy_restart", 0, 0, 4, 1, 6);

    // Reset after the third write aborts the command.
    run(20, 30, 3, 3, 2, -1, 3, 6);
    build_model(20, 30, 3, 3, 2);
    chk("abort.timeout", timed_out, 0);
    chk("abort.wr_count", wr_q.size(), 3);
    chk("abort.wr_seq_first_bad", first_bad(3), -1);
    chk("abort.done_count", done_q.size(), 0);
    chk("abort.busy_fall", idle_seen, abort_idx + 1);

    tbl[0] = '{10, 5, 2, 2, 5, 4, 1610, 1931, 6};
    tbl[1] = '{0, 0, 0, 7, 1, 0, -1, -1, 2};
`ifdef FB_RECT_CLIP_EN
    tbl[2] = '{318, 239, 4, 2, 7, 2, 76798, 76799, 10};
`else
    tbl[2] = '{318, 239, 4, 2, 7, 8, 76798, 77121, 10};
`endif
    tbl[3] = '{0, 0, 320, 240, 4, 76800, 0, 76799, 76802};

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      run(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c, -1, 0, 4);
      check_cmd(tag, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c);
      chk({tag, ".n"}, wr_q.size(), tbl[i].n);
      chk({tag, ".first"}, wr_q.size() > 0 ? wr_q[0].addr : -1, tbl[i].first);
      chk({tag, ".last"}, wr_q.size() > 0 ? wr_q[wr_q.size() - 1].addr : -1, tbl[i].last);
      chk({tag, ".done_tbl"}, done_q.size() > 0 ? done_q[0] : -1, tbl[i].done_idx);
    end

    for (int n = 0; n < 30; n++) begin
      int x, y, w, h, c;
      x = int'($urandom_range(511, 0));
      y = int'($urandom_range(255, 0));
      w = int'($urandom_range(8, 0));
      h = int'($urandom_range(8, 0));
      c = int'($urandom_range(7, 0));
      run(x, y, w, h, c, -1, 0, 3);
      check_cmd($sformatf("rnd%0d", n), x, y, w, h, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
